// File: rtl/imem_loader_if.sv
// -----------------------------------------------------------------------------
// imem_loader_if
//
// Bundles the signals of the boot loader into one interface:
//   - byte stream in:  byte_valid, byte_data, byte_ready
//   - RAM write port:  im_we, im_addr, im_wdata
//   - status:          cpu_stall, done, err
//
// Modports:
//   master - the loader: consumes the stream, drives the RAM port and status.
//   slave  - its environment: the stream source, the RAM and the CPU.
// -----------------------------------------------------------------------------
interface imem_loader_if #(
    parameter int AW = 11
);
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          im_we;
    logic [AW-1:0] im_addr;
    logic [31:0]   im_wdata;
    logic          cpu_stall;
    logic          done;
    logic          err;

    modport master (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output im_we,
        output im_addr,
        output im_wdata,
        output cpu_stall,
        output done,
        output err
    );

    modport slave (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  im_we,
        input  im_addr,
        input  im_wdata,
        input  cpu_stall,
        input  done,
        input  err
    );
endinterface

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Boot-time writer for the instruction RAM. It parses a framed byte stream
//   0xA5, CNT_HI, CNT_LO, BASE_HI, BASE_LO, 4*N payload bytes, CHK
// packs the payload big-endian into 32-bit words and writes word k to physical
// RAM index BASE+k. The CPU fetch path is held stalled while a frame is open.
//
// Ports:
//   Clk    - system clock, rising edge
//   Clr_n  - asynchronous active-low reset
//   bus    - imem_loader_if.master:
//              byte_valid/byte_data in, byte_ready out (stream handshake)
//              im_we/im_addr/im_wdata out (one-cycle RAM write)
//              cpu_stall out (IFU PC hold), done/err out (one-cycle pulses)
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | hunting for 0xA5, other bytes discarded
// CNT_H   | expecting word count, high byte
// CNT_L   | expecting word count, low byte
// BASE_H  | expecting base word index, high byte
// BASE_L  | expecting base word index, low byte; range check on leaving
// DATA    | packing payload bytes, one RAM write per 4 bytes
// CHECK   | expecting checksum byte
// DONE    | one-cycle success pulse, stream stalled
// ERR     | one-cycle failure pulse (range, checksum, timeout), stream stalled
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int AW      = 11,
    parameter int DEPTH   = 2048,
    parameter int TIMEOUT = 65535
) (
    input  logic          Clk,
    input  logic          Clr_n,
    imem_loader_if.master bus
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_CNT_H  = 4'd1,
        S_CNT_L  = 4'd2,
        S_BASE_H = 4'd3,
        S_BASE_L = 4'd4,
        S_DATA   = 4'd5,
        S_CHECK  = 4'd6,
        S_DONE   = 4'd7,
        S_ERR    = 4'd8
    } state_t;

    // Idle timer is a down-counter reloaded with TIMEOUT-1; reaching zero with
    // no byte accepted marks the TIMEOUT-th consecutive idle cycle.
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);
    localparam logic [16:0]   DEPTH_17 = 17'(DEPTH);

    state_t        state_q;
    state_t        state_d;

    logic          rdy_en_q;
    logic          cpu_stall_q;
    logic          im_we_q;
    logic [AW-1:0] im_addr_q;
    logic [31:0]   im_wdata_q;

    logic [15:0]   cnt_q;
    logic [7:0]    base_hi_q;
    logic [15:0]   waddr_q;
    logic [15:0]   words_left_q;
    logic [1:0]    bcnt_q;
    logic [23:0]   shreg_q;
    logic [7:0]    chk_q;
    logic [TW-1:0] tmr_q;

    logic          byte_ready_c;
    logic          accept;
    logic          timed;
    logic          tmo;
    logic [7:0]    chk_nx;
    logic [15:0]   base_nx;
    logic [16:0]   end_addr;

    function automatic logic in_frame(state_t s);
        return (s == S_CNT_H) || (s == S_CNT_L) || (s == S_BASE_H) ||
               (s == S_BASE_L) || (s == S_DATA) || (s == S_CHECK);
    endfunction

    // byte_ready is gated by rdy_en_q so it stays low while Clr_n is asserted
    // even though the state register already reads IDLE.
    assign byte_ready_c = rdy_en_q && (state_q != S_DONE) && (state_q != S_ERR);
    assign accept       = bus.byte_valid && byte_ready_c;
    assign timed        = in_frame(state_q);
    assign tmo          = (tmr_q == '0);
    assign chk_nx       = chk_q ^ bus.byte_data;
    assign base_nx      = {base_hi_q, bus.byte_data};
    // 17-bit sum so BASE+N cannot wrap past the top of the 16-bit range.
    assign end_addr     = {1'b0, base_nx} + {1'b0, cnt_q};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept && (bus.byte_data == 8'hA5)) begin
                    state_d = S_CNT_H;
                end
            end
            S_CNT_H: begin
                if (accept) state_d = S_CNT_L;
            end
            S_CNT_L: begin
                if (accept) state_d = S_BASE_H;
            end
            S_BASE_H: begin
                if (accept) state_d = S_BASE_L;
            end
            S_BASE_L: begin
                if (accept) begin
                    if (end_addr > DEPTH_17) begin
                        state_d = S_ERR;
                    end else if (cnt_q == 16'd0) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept && (bcnt_q == 2'd3) && (words_left_q == 16'd1)) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (accept) begin
                    state_d = (chk_nx == 8'h00) ? S_DONE : S_ERR;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (timed && !accept && tmo) begin
            state_d = S_ERR;
        end
    end

    always_ff @(posedge Clk or negedge Clr_n) begin
        if (!Clr_n) begin
            state_q     <= S_IDLE;
            rdy_en_q    <= 1'b0;
            cpu_stall_q <= 1'b0;
            tmr_q       <= TMR_LOAD;
        end else begin
            state_q     <= state_d;
            rdy_en_q    <= 1'b1;
            // Registered copy of "next state is inside a frame": rises the
            // cycle after 0xA5, already low in the DONE/ERR pulse cycle.
            cpu_stall_q <= in_frame(state_d);
            if (accept || !timed) begin
                tmr_q <= TMR_LOAD;
            end else if (!tmo) begin
                tmr_q <= tmr_q - 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Clr_n) begin
        if (!Clr_n) begin
            im_we_q      <= 1'b0;
            im_addr_q    <= '0;
            im_wdata_q   <= '0;
            cnt_q        <= '0;
            base_hi_q    <= '0;
            waddr_q      <= '0;
            words_left_q <= '0;
            bcnt_q       <= '0;
            shreg_q      <= '0;
            chk_q        <= '0;
        end else begin
            im_we_q <= 1'b0;
            if (accept) begin
                // Checksum covers every byte after the 0xA5 sync byte.
                chk_q <= (state_q == S_IDLE) ? 8'h00 : chk_nx;
                unique case (state_q)
                    S_CNT_H:  cnt_q[15:8] <= bus.byte_data;
                    S_CNT_L:  cnt_q[7:0]  <= bus.byte_data;
                    S_BASE_H: base_hi_q   <= bus.byte_data;
                    S_BASE_L: begin
                        waddr_q      <= base_nx;
                        words_left_q <= cnt_q;
                        bcnt_q       <= 2'd0;
                    end
                    S_DATA: begin
                        bcnt_q  <= bcnt_q + 2'd1;
                        shreg_q <= {shreg_q[15:0], bus.byte_data};
                        if (bcnt_q == 2'd3) begin
                            im_we_q      <= 1'b1;
                            im_wdata_q   <= {shreg_q, bus.byte_data};
                            im_addr_q    <= waddr_q[AW-1:0];
                            waddr_q      <= waddr_q + 16'd1;
                            words_left_q <= words_left_q - 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.byte_ready = byte_ready_c;
    assign bus.im_we      = im_we_q;
    assign bus.im_addr    = im_addr_q;
    assign bus.im_wdata   = im_wdata_q;
    assign bus.cpu_stall  = cpu_stall_q;
    assign bus.done       = (state_q == S_DONE);
    assign bus.err        = (state_q == S_ERR);

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    localparam int AW  = 11;
    localparam int TMO = 40;

    logic Clk;
    logic Clr_n;

    imem_loader_if #(.AW(AW)) bus ();

    imem_loader #(
        .AW     (AW),
        .DEPTH  (2048),
        .TIMEOUT(TMO)
    ) dut (
        .Clk  (Clk),
        .Clr_n(Clr_n),
        .bus  (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int passed = 0;
    int total  = 0;

    // Event log sampled on the falling edge, away from the active edge.
    int          we_cnt    = 0;
    int          done_cnt  = 0;
    int          err_cnt   = 0;
    int          stall_bad = 0;
    logic [31:0] log_data [64];
    logic [31:0] log_addr [64];

    always @(negedge Clk) begin
        if (bus.im_we) begin
            log_data[we_cnt % 64] <= bus.im_wdata;
            log_addr[we_cnt % 64] <= 32'(bus.im_addr);
            we_cnt <= we_cnt + 1;
        end
        if (bus.done) done_cnt <= done_cnt + 1;
        if (bus.err)  err_cnt  <= err_cnt + 1;
        if (bus.cpu_stall && (bus.done || bus.err)) stall_bad <= stall_bad + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Offers one byte and returns at posedge+1 after it is accepted.
    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        while (!bus.byte_ready && n < 50) begin
            @(negedge Clk);
            n++;
        end
        check("send_ready_wait", 32'(n < 50), 32'd1);
        @(posedge Clk);
        #1;
        bus.byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send(w[31:24]);
        send(w[23:16]);
        send(w[15:8]);
        send(w[7:0]);
    endtask

    task automatic settle();
        @(negedge Clk);
        #1;
    endtask

    int w0, d0, e0, k;

    initial begin
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        Clr_n = 1'b1;
        #3 Clr_n = 1'b0;
        #1;
        check("rst_byte_ready", 32'(bus.byte_ready), 32'd0);
        check("rst_im_we",      32'(bus.im_we),      32'd0);
        check("rst_im_addr",    32'(bus.im_addr),    32'd0);
        check("rst_im_wdata",   bus.im_wdata,        32'd0);
        check("rst_cpu_stall",  32'(bus.cpu_stall),  32'd0);
        check("rst_done",       32'(bus.done),       32'd0);
        check("rst_err",        32'(bus.err),        32'd0);
        repeat (2) @(negedge Clk);
        Clr_n = 1'b1;
        @(posedge Clk);
        #1;
        check("ready_after_rst", 32'(bus.byte_ready), 32'd1);

        // Good frame N=2 BASE=0, CHK = 02^3C^01 = 3F
        w0 = we_cnt; d0 = done_cnt; e0 = err_cnt;
        check("t1_stall_before", 32'(bus.cpu_stall), 32'd0);
        send(8'hA5);
        check("t1_stall_rise", 32'(bus.cpu_stall), 32'd1);
        send(8'h00); send(8'h02); send(8'h00); send(8'h00);
        send_word(32'h3C010000);
        check("t1_we0",    32'(bus.im_we),   32'd1);
        check("t1_addr0",  32'(bus.im_addr), 32'd0);
        check("t1_data0",  bus.im_wdata,     32'h3C010000);
        send_word(32'h00000000);
        check("t1_we1",    32'(bus.im_we),   32'd1);
        check("t1_addr1",  32'(bus.im_addr), 32'd1);
        check("t1_data1",  bus.im_wdata,     32'h00000000);
        send(8'h3F);
        check("t1_done",       32'(bus.done),       32'd1);
        check("t1_err",        32'(bus.err),        32'd0);
        check("t1_stall_fall", 32'(bus.cpu_stall),  32'd0);
        check("t1_ready_done", 32'(bus.byte_ready), 32'd0);
        @(posedge Clk);
        #1;
        check("t1_done_pulse", 32'(bus.done),       32'd0);
        check("t1_addr_hold",  32'(bus.im_addr),    32'd1);
        settle();
        check("t1_we_count",   32'(we_cnt - w0),   32'd2);
        check("t1_done_count", 32'(done_cnt - d0), 32'd1);
        check("t1_log0",       log_data[w0 % 64],  32'h3C010000);
        check("t1_log1_addr",  log_addr[(w0 + 1) % 64], 32'd1);

        // Same frame, bad checksum
        w0 = we_cnt; d0 = done_cnt; e0 = err_cnt;
        send(8'hA5);
        send(8'h00); send(8'h02); send(8'h00); send(8'h00);
        send_word(32'h3C010000);
        send_word(32'h00000000);
        send(8'h3E);
        check("t2_err",   32'(bus.err),  32'd1);
        check("t2_done",  32'(bus.done), 32'd0);
        settle();
        check("t2_we_count",   32'(we_cnt - w0),   32'd2);
        check("t2_err_count",  32'(err_cnt - e0),  32'd1);
        check("t2_done_count", 32'(done_cnt - d0), 32'd0);

        // Out of range: BASE=0x07FF N=2
        w0 = we_cnt; d0 = done_cnt; e0 = err_cnt;
        send(8'hA5);
        send(8'h00); send(8'h02); send(8'h07); send(8'hFF);
        check("t3_err_now",   32'(bus.err),        32'd1);
        check("t3_ready_low", 32'(bus.byte_ready), 32'd0);
        check("t3_stall",     32'(bus.cpu_stall),  32'd0);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        send(8'h55); send(8'h66); send(8'h77); send(8'h88); send(8'h12);
        check("t3_stall_after", 32'(bus.cpu_stall), 32'd0);
        settle();
        check("t3_we_count",   32'(we_cnt - w0),   32'd0);
        check("t3_err_count",  32'(err_cnt - e0),  32'd1);
        check("t3_done_count", 32'(done_cnt - d0), 32'd0);

        // Exact fit at the top: BASE=0x07FE N=2, CHK = FB^66 = 9D
        w0 = we_cnt; d0 = done_cnt;
        send(8'hA5);
        send(8'h00); send(8'h02); send(8'h07); send(8'hFE);
        send_word(32'h11223344);
        send_word(32'hDEADBEEF);
        check("t4_top_addr", 32'(bus.im_addr), 32'h7FF);
        check("t4_top_data", bus.im_wdata,     32'hDEADBEEF);
        send(8'h9D);
        check("t4_done", 32'(bus.done), 32'd1);
        settle();
        check("t4_first_addr", log_addr[w0 % 64], 32'h7FE);
        check("t4_we_count",   32'(we_cnt - w0),  32'd2);

        // N=0, BASE=0x0123, CHK = 01^23 = 22
        w0 = we_cnt; d0 = done_cnt;
        send(8'hA5);
        send(8'h00); send(8'h00); send(8'h01); send(8'h23);
        send(8'h22);
        check("t5_done", 32'(bus.done), 32'd1);
        settle();
        check("t5_we_count",   32'(we_cnt - w0),   32'd0);
        check("t5_done_count", 32'(done_cnt - d0), 32'd1);

        // Garbage then N=1 BASE=0x0010 word CAFEF00D, CHK = 11^C9 = D8
        w0 = we_cnt;
        send(8'h00);
        send(8'hFF);
        check("t6_garbage_stall", 32'(bus.cpu_stall),  32'd0);
        check("t6_garbage_ready", 32'(bus.byte_ready), 32'd1);
        send(8'hA5);
        send(8'h00); send(8'h01); send(8'h00); send(8'h10);
        send_word(32'hCAFEF00D);
        send(8'hD8);
        check("t6_done", 32'(bus.done), 32'd1);
        settle();
        check("t6_addr", log_addr[w0 % 64], 32'h010);
        check("t6_data", log_data[w0 % 64], 32'hCAFEF00D);

        // Timeout after the 2nd payload byte
        w0 = we_cnt; e0 = err_cnt;
        send(8'hA5);
        send(8'h00); send(8'h01); send(8'h00); send(8'h20);
        send(8'h12); send(8'h34);
        k = 0;
        while (!bus.err && k < TMO + 20) begin
            @(posedge Clk);
            #1;
            k++;
        end
        check("t7_tmo_err",     32'(bus.err),                      32'd1);
        check("t7_tmo_latency", 32'((k >= TMO) && (k <= TMO + 1)), 32'd1);
        check("t7_tmo_stall",   32'(bus.cpu_stall),                32'd0);
        settle();
        check("t7_we_count",  32'(we_cnt - w0),  32'd0);
        check("t7_err_count", 32'(err_cnt - e0), 32'd1);

        // Reset during 3rd word of an N=4 frame at BASE=0x0100
        w0 = we_cnt;
        send(8'hA5);
        send(8'h00); send(8'h04); send(8'h01); send(8'h00);
        send_word(32'h01020304);
        send_word(32'h05060708);
        send(8'h09); send(8'h0A);
        check("t8_stall_pre", 32'(bus.cpu_stall), 32'd1);
        #2 Clr_n = 1'b0;
        #1;
        check("t8_rst_ready",  32'(bus.byte_ready), 32'd0);
        check("t8_rst_we",     32'(bus.im_we),      32'd0);
        check("t8_rst_addr",   32'(bus.im_addr),    32'd0);
        check("t8_rst_wdata",  bus.im_wdata,        32'd0);
        check("t8_rst_stall",  32'(bus.cpu_stall),  32'd0);
        check("t8_rst_done",   32'(bus.done),       32'd0);
        check("t8_rst_err",    32'(bus.err),        32'd0);
        repeat (2) @(negedge Clk);
        Clr_n = 1'b1;
        @(posedge Clk);
        #1;
        send(8'h0B); send(8'h0C);
        settle();
        check("t8_we_count", 32'(we_cnt - w0), 32'd2);
        // Fresh frame N=1 BASE=0 word 00000001, CHK = 01^01 = 00
        w0 = we_cnt; d0 = done_cnt;
        send(8'hA5);
        send(8'h00); send(8'h01); send(8'h00); send(8'h00);
        send_word(32'h00000001);
        send(8'h00);
        check("t8_fresh_done", 32'(bus.done), 32'd1);
        settle();
        check("t8_fresh_we",   32'(we_cnt - w0),     32'd1);
        check("t8_fresh_data", log_data[w0 % 64],    32'h00000001);

        check("stall_vs_pulse", 32'(stall_bad), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the instruction memory. Receives a framed byte stream (host link, UART receiver, or testbench), packs the payload into 32-bit words, and writes them into the instruction RAM at physical word indices. It holds the CPU fetch path stalled for the duration of a frame. It is the write-side counterpart of the fetch path: the IFU/IM pair only reads words, and this block is the only writer of the array.

## Interface
Parameters:
- AW, 11, instruction RAM word-address width (2048 words).
- DEPTH, 2048, number of RAM words; legal word indices are 0..DEPTH-1.
- TIMEOUT, 65535, maximum idle cycles allowed between accepted bytes inside a frame.

Ports:
- Clk  in  1  system clock; every flop updates on posedge.
- Clr_n  in  1  asynchronous, active-low reset.
- byte_valid  in  1  byte_data is valid this cycle.
- byte_data  in  8  incoming stream byte.
- byte_ready  out  1  loader can accept a byte this cycle.
- im_we  out  1  one-cycle write strobe to the instruction RAM.
- im_addr  out  AW  physical RAM word index, i.e. the index after the IM bit-10 remap, not the PC.
- im_wdata  out  32  word to write.
- cpu_stall  out  1  holds the IFU PC while a frame is in progress.
- done  out  1  one-cycle pulse: frame completed and checksum good.
- err  out  1  one-cycle pulse: frame aborted or checksum bad.

## Operation
- A byte transfers on a posedge when byte_valid and byte_ready are both 1.
- Frame format: 0xA5, CNT_HI, CNT_LO, BASE_HI, BASE_LO, 4*N payload bytes, CHK.
  - N = {CNT_HI,CNT_LO} and BASE = {BASE_HI,BASE_LO}, both 16-bit big-endian.
  - Payload words are big-endian: the first byte lands in bits [31:24].
- States: IDLE, CNT_H, CNT_L, BASE_H, BASE_L, DATA, CHECK, DONE, ERR.
- IDLE:
  - byte_ready=1.
  - 0xA5 moves to CNT_H.
  - Any other byte is accepted and discarded.
- CNT_H, CNT_L, BASE_H, BASE_L each capture one byte, then advance to the next state in the list.
- Leaving BASE_L, in this order:
  - If BASE+N > DEPTH, go to ERR. No writes occur.
  - Else if N==0, go to CHECK.
  - Else go to DATA.
- DATA:
  - A 2-bit byte counter shifts bytes into a 32-bit shift register.
  - On the 4th byte the word is registered to im_wdata, im_addr=BASE+k (k = word number, 0-based), and im_we=1 for the next cycle.
  - After word N-1 the state moves to CHECK.
- Checksum:
  - A running XOR covers every byte after 0xA5, including CHK.
  - CHECK accepts one byte. If the final XOR is 0, go to DONE, otherwise ERR.
  - Words already written are not rolled back.
- DONE and ERR:
  - Each lasts one cycle, pulses done or err, has byte_ready=0, then returns to IDLE.
- Timeout:
  - An idle counter clears on every accepted byte and counts otherwise in all states except IDLE, DONE and ERR.
  - Reaching TIMEOUT goes to ERR.
- Address arithmetic: BASE+N is computed at 17 bits, so there is no wrap. im_addr = low AW bits of BASE+k, always < DEPTH.

## Timing
- Reset values: byte_ready=0, im_we=0, im_addr=0, im_wdata=0, cpu_stall=0, done=0, err=0. State is IDLE.
  - byte_ready is 1 from the first cycle after Clr_n deasserts.
- byte_ready is combinational from state: 1 in every state except DONE and ERR. There is no backpressure inside a frame.
- cpu_stall:
  - Registered.
  - Rises the cycle after 0xA5 is accepted.
  - Falls in the same cycle that done or err is high.
- Write latency:
  - im_we is high exactly 1 cycle, starting the cycle after the 4th byte of a word is accepted.
  - im_addr and im_wdata are stable while im_we=1 and hold their values afterwards.
- Back-to-back bytes (valid every cycle) give one write every 4 cycles. Minimum frame length is 6+4N accepted bytes.
- 0xA5 arriving inside a frame is treated as data. There is no resynchronisation except via timeout or reset.
- Clr_n asserted mid-frame: immediate return to IDLE, cpu_stall=0, and no further writes. Partially written RAM contents are left as they are.

## Test plan
- Good frame with N=2, BASE=0x0000, words 0x3C010000 and 0x00000000, correct CHK:
  - im_we pulses twice, at addresses 0 and 1, with those data.
  - done pulses once.
  - cpu_stall is high from the cycle after 0xA5 until the done cycle.
- Same frame with CHK XOR 0x01: both writes still occur, then err pulses and done stays 0.
- BASE=0x07FF, N=2:
  - err pulses right after BASE_LO is accepted.
  - im_we never rises.
  - Remaining bytes are discarded in IDLE.
- N=0 with CHK=XOR of the 4 header bytes: done pulses with no writes.
- Garbage bytes 0x00 and 0xFF before 0xA5: discarded, cpu_stall stays 0, and the following frame loads normally. Also stall byte_valid for TIMEOUT cycles after the 2nd payload byte: err pulses and cpu_stall drops.
- Assert Clr_n low during the 3rd payload word of an N=4 frame: all outputs go to reset values asynchronously, no further im_we, and a fresh frame afterwards completes with done.
